// File: rtl/adc_multitrigger_pkg.sv
// Shared definitions for the N-channel ADC trigger.
// Contents: per-channel FSM state type, register offsets inside a channel
// window and the global window, status bit positions, and a byte-merge
// helper used by every byte-addressed multi-byte register.
// Optional feature macro used by the design: ADC_MULTITRIGGER_HYST_EN.
package adc_multitrigger_pkg;

  typedef enum logic [1:0] {
    CH_OFF    = 2'd0,
    CH_ARMING = 2'd1,
    CH_ARMED  = 2'd2
  } ch_state_e;

  // Channel window offsets (wb_adr_i[7] == 0)
  localparam logic [2:0] OFF_STATUS    = 3'd0;
  localparam logic [2:0] OFF_THRESH_LO = 3'd1;
  localparam logic [2:0] OFF_THRESH_HI = 3'd2;
  localparam logic [2:0] OFF_HYST_LO   = 3'd3;
  localparam logic [2:0] OFF_HYST_HI   = 3'd4;

  // Global window offsets (wb_adr_i[7] == 1)
  localparam logic [2:0] OFF_LAST_SRC   = 3'd0;
  localparam logic [2:0] OFF_HOLDOFF_LO = 3'd1;
  localparam logic [2:0] OFF_HOLDOFF_HI = 3'd2;

  // Status register bit positions
  localparam int ST_ENABLE      = 0;
  localparam int ST_CMP_GREATER = 1;
  localparam int ST_CMP_ABS     = 2;
  localparam int ST_HYST_EN     = 3;

  // Replace one byte of a 16-bit view of a register.
  function automatic logic [15:0] merge_byte(input logic [15:0] cur,
                                             input logic        hi,
                                             input logic [7:0]  dat);
    merge_byte = hi ? {dat, cur[7:0]} : {cur[15:8], dat};
  endfunction

endpackage

// File: rtl/adc_multitrigger_if.sv
// Wishbone register-slave bundle for adc_multitrigger.
// Signals: wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i[15:0], wb_dat_i[7:0]
// (master -> slave); wb_dat_o[7:0], wb_ack_o (slave -> master).
// Handshake: a transfer happens on every clock edge where wb_stb_i and
// wb_cyc_i are both 1. wb_ack_o is constant 1 (zero wait states), so a write
// is committed on that same edge and read data is valid combinationally
// from wb_adr_i during the cycle.
interface adc_multitrigger_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [15:0] wb_adr_i;
  logic [7:0]  wb_dat_i;
  logic [7:0]  wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/adc_multitrigger_chan.sv
// One trigger channel: sample register, threshold/mode registers, FSM, hit.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   adc_i         raw sample for this channel (registered here)
//   sq_active_i   sequencer capture active
//   fire_i        global trigger decision of this cycle
//   wr_en_i       register write addressed to this channel
//   off_i         register offset (read and write)
//   wr_dat_i      write data byte
//   rd_dat_o      read data byte for off_i
//   hit_o         channel condition met while ARMED and enabled
//   state_o       FSM state (debug)
// Macro ADC_MULTITRIGGER_HYST_EN adds the hyst register and hysteretic re-arm.
module adc_multitrigger_chan
  import adc_multitrigger_pkg::*;
#(
  parameter int ADC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADC_WIDTH-1:0] adc_i,
  input  logic                 sq_active_i,
  input  logic                 fire_i,
  input  logic                 wr_en_i,
  input  logic [2:0]           off_i,
  input  logic [7:0]           wr_dat_i,
  output logic [7:0]           rd_dat_o,
  output logic                 hit_o,
  output ch_state_e            state_o
);

  logic [ADC_WIDTH-1:0] sample_q;
  logic [ADC_WIDTH-1:0] thresh_q, thresh_d;
  logic                 enable_q, enable_d;
  logic                 cmp_greater_q, cmp_greater_d;
  logic                 cmp_abs_q, cmp_abs_d;
  ch_state_e            state_q, state_d;
  logic                 greater, cond, arm_ok;
  logic [15:0]          thresh_wide;

  assign thresh_wide = 16'(thresh_q);

`ifdef ADC_MULTITRIGGER_HYST_EN
  localparam logic HYST_FLAG = 1'b1;
  logic [ADC_WIDTH-1:0] hyst_q, hyst_d;
  logic [15:0]          hyst_wide;
  logic [ADC_WIDTH:0]   upper_bound, lower_sum;
  assign hyst_wide = 16'(hyst_q);
`else
  localparam logic HYST_FLAG = 1'b0;
`endif

  // Register writes. Threshold, hyst and mode are frozen while enabled; a
  // status write while enabled can only clear enable.
  always_comb begin
    enable_d      = enable_q;
    cmp_greater_d = cmp_greater_q;
    cmp_abs_d     = cmp_abs_q;
    thresh_d      = thresh_q;
`ifdef ADC_MULTITRIGGER_HYST_EN
    hyst_d        = hyst_q;
`endif
    if (wr_en_i) begin
      if (off_i == OFF_STATUS) begin
        if (!enable_q) begin
          enable_d      = wr_dat_i[ST_ENABLE];
          cmp_greater_d = wr_dat_i[ST_CMP_GREATER];
          cmp_abs_d     = wr_dat_i[ST_CMP_ABS];
        end else if (!wr_dat_i[ST_ENABLE]) begin
          enable_d = 1'b0;
        end
      end else if (!enable_q &&
                   (off_i == OFF_THRESH_LO || off_i == OFF_THRESH_HI)) begin
        thresh_d = ADC_WIDTH'(merge_byte(thresh_wide, off_i == OFF_THRESH_HI, wr_dat_i));
      end
`ifdef ADC_MULTITRIGGER_HYST_EN
      else if (!enable_q &&
               (off_i == OFF_HYST_LO || off_i == OFF_HYST_HI)) begin
        hyst_d = ADC_WIDTH'(merge_byte(hyst_wide, off_i == OFF_HYST_HI, wr_dat_i));
      end
`endif
    end
  end

  assign greater = thresh_q > sample_q;
  assign cond    = (greater == cmp_greater_q);

`ifdef ADC_MULTITRIGGER_HYST_EN
  // One extra bit so the bounds never wrap; an unreachable bound simply
  // never arms.
  assign upper_bound = {1'b0, thresh_q} + {1'b0, hyst_q};
  assign lower_sum   = {1'b0, sample_q} + {1'b0, hyst_q};
  always_comb begin
    if (hyst_q == '0)       arm_ok = !cond;
    else if (cmp_greater_q) arm_ok = {1'b0, sample_q} > upper_bound;
    else                    arm_ok = lower_sum < {1'b0, thresh_q};
  end
`else
  assign arm_ok = !cond;
`endif

  // FSM next state. Level mode lives in ARMED; edge (abs) mode must see the
  // inverse condition in ARMING before it may hit again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CH_OFF: begin
        if (enable_q) state_d = cmp_abs_q ? CH_ARMING : CH_ARMED;
      end
      CH_ARMING: begin
        if (!enable_q)                    state_d = CH_OFF;
        else if (!cmp_abs_q)              state_d = CH_ARMED;
        else if (sq_active_i && arm_ok)   state_d = CH_ARMED;
      end
      CH_ARMED: begin
        if (!enable_q)                                  state_d = CH_OFF;
        else if (cmp_abs_q && (!sq_active_i || fire_i)) state_d = CH_ARMING;
      end
      default: state_d = CH_OFF;
    endcase
  end

  assign hit_o   = enable_q && (state_q == CH_ARMED) && cond;
  assign state_o = state_q;

  always_comb begin
    rd_dat_o = 8'h00;
    case (off_i)
      OFF_STATUS:    rd_dat_o = {4'b0000, HYST_FLAG, cmp_abs_q, cmp_greater_q, enable_q};
      OFF_THRESH_LO: rd_dat_o = thresh_wide[7:0];
      OFF_THRESH_HI: rd_dat_o = thresh_wide[15:8];
`ifdef ADC_MULTITRIGGER_HYST_EN
      OFF_HYST_LO:   rd_dat_o = hyst_wide[7:0];
      OFF_HYST_HI:   rd_dat_o = hyst_wide[15:8];
`endif
      default:       rd_dat_o = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q      <= '0;
      thresh_q      <= '0;
      enable_q      <= 1'b0;
      cmp_greater_q <= 1'b0;
      cmp_abs_q     <= 1'b0;
      state_q       <= CH_OFF;
`ifdef ADC_MULTITRIGGER_HYST_EN
      hyst_q        <= '0;
`endif
    end else begin
      sample_q      <= adc_i;
      thresh_q      <= thresh_d;
      enable_q      <= enable_d;
      cmp_greater_q <= cmp_greater_d;
      cmp_abs_q     <= cmp_abs_d;
      state_q       <= state_d;
`ifdef ADC_MULTITRIGGER_HYST_EN
      hyst_q        <= hyst_d;
`endif
    end
  end

endmodule

// File: rtl/adc_multitrigger.sv
// N-channel ADC trigger with Wishbone register slave.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   sq_active      sequencer capture active; triggers only while 1
//   sq_trigger     one-cycle trigger pulse
//   adc            packed samples, channel 0 in the LSBs
//   wb             Wishbone slave (adc_multitrigger_if.slave)
//   dbg_state_o    per-channel FSM state, 2 bits per channel (debug)
// Map: wb_adr_i[7]=0 -> channel wb_adr_i[6:3], offset wb_adr_i[2:0];
//      wb_adr_i[7]=1 -> global (last_src, holdoff lo/hi).
// Macro ADC_MULTITRIGGER_HYST_EN enables per-channel hysteresis.
module adc_multitrigger
  import adc_multitrigger_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int ADC_WIDTH     = 8,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sq_active,
  output logic                          sq_trigger,
  input  logic [CHANNELS*ADC_WIDTH-1:0] adc,
  adc_multitrigger_if.slave             wb,
  output logic [2*CHANNELS-1:0]         dbg_state_o
);

  logic                     wr_stb;
  logic                     fire;
  logic [CHANNELS-1:0]      hit;
  logic [7:0]               chan_rd [CHANNELS];
  ch_state_e                ch_state [CHANNELS];
  logic [3:0]               hit_idx;
  logic [7:0]               rd_dat;

  logic [HOLDOFF_WIDTH-1:0] holdoff_q, holdoff_d;
  logic [HOLDOFF_WIDTH-1:0] holdoff_cnt_q, holdoff_cnt_d;
  logic [3:0]               last_src_q, last_src_d;
  logic                     sq_trigger_q;
  logic [15:0]              holdoff_wide;

  // Upper address byte is not decoded.
  logic unused_adr_hi;
  assign unused_adr_hi = &{1'b0, wb.wb_adr_i[15:8]};

  assign wr_stb       = wb.wb_stb_i && wb.wb_cyc_i && wb.wb_we_i;
  assign wb.wb_ack_o  = 1'b1;
  assign holdoff_wide = 16'(holdoff_q);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    adc_multitrigger_chan #(.ADC_WIDTH(ADC_WIDTH)) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .adc_i       (adc[c*ADC_WIDTH +: ADC_WIDTH]),
      .sq_active_i (sq_active),
      .fire_i      (fire),
      .wr_en_i     (wr_stb && !wb.wb_adr_i[7] && (wb.wb_adr_i[6:3] == 4'(c))),
      .off_i       (wb.wb_adr_i[2:0]),
      .wr_dat_i    (wb.wb_dat_i),
      .rd_dat_o    (chan_rd[c]),
      .hit_o       (hit[c]),
      .state_o     (ch_state[c])
    );
    assign dbg_state_o[2*c +: 2] = ch_state[c];
  end

  // Lowest-index hitting channel wins.
  always_comb begin
    hit_idx = 4'd0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (hit[c]) hit_idx = 4'(c);
    end
  end

  assign fire = sq_active && (holdoff_cnt_q == '0) && (|hit);

  always_comb begin
    holdoff_d = holdoff_q;
    if (wr_stb && wb.wb_adr_i[7] &&
        (wb.wb_adr_i[2:0] == OFF_HOLDOFF_LO || wb.wb_adr_i[2:0] == OFF_HOLDOFF_HI)) begin
      holdoff_d = HOLDOFF_WIDTH'(merge_byte(holdoff_wide,
                                            wb.wb_adr_i[2:0] == OFF_HOLDOFF_HI,
                                            wb.wb_dat_i));
    end
  end

  // Holdoff reloads on fire and otherwise counts down to 0 and stays there.
  always_comb begin
    holdoff_cnt_d = holdoff_cnt_q;
    last_src_d    = last_src_q;
    if (fire) begin
      holdoff_cnt_d = holdoff_q;
      last_src_d    = hit_idx;
    end else if (holdoff_cnt_q != '0) begin
      holdoff_cnt_d = holdoff_cnt_q - HOLDOFF_WIDTH'(1);
    end
  end

  always_comb begin
    rd_dat = 8'h00;
    if (wb.wb_adr_i[7]) begin
      case (wb.wb_adr_i[2:0])
        OFF_LAST_SRC:   rd_dat = {4'b0000, last_src_q};
        OFF_HOLDOFF_LO: rd_dat = holdoff_wide[7:0];
        OFF_HOLDOFF_HI: rd_dat = holdoff_wide[15:8];
        default:        rd_dat = 8'h00;
      endcase
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wb.wb_adr_i[6:3] == 4'(c)) rd_dat = chan_rd[c];
      end
    end
  end

  assign wb.wb_dat_o = rd_dat;
  assign sq_trigger  = sq_trigger_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      holdoff_q     <= '0;
      holdoff_cnt_q <= '0;
      last_src_q    <= 4'd0;
      sq_trigger_q  <= 1'b0;
    end else begin
      holdoff_q     <= holdoff_d;
      holdoff_cnt_q <= holdoff_cnt_d;
      last_src_q    <= last_src_d;
      sq_trigger_q  <= fire;
    end
  end

endmodule

// File: tb/tb_adc_multitrigger.sv
// Bench for adc_multitrigger (CHANNELS=2, ADC_WIDTH=12, HOLDOFF_WIDTH=16).
// Register reads and trigger pulses are checked by a negedge monitor against
// expected queues filled by the stimulus process.
module tb_adc_multitrigger;
  import adc_multitrigger_pkg::*;

  localparam int CHANNELS      = 2;
  localparam int ADC_WIDTH     = 12;
  localparam int HOLDOFF_WIDTH = 16;
`ifdef ADC_MULTITRIGGER_HYST_EN
  localparam logic [7:0] HB = 8'h08;
`else
  localparam logic [7:0] HB = 8'h00;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  logic                          sq_active = 1'b0;
  logic                          sq_trigger;
  logic [ADC_WIDTH-1:0]          adc0 = '0;
  logic [ADC_WIDTH-1:0]          adc1 = '0;
  logic [CHANNELS*ADC_WIDTH-1:0] adc;
  logic [2*CHANNELS-1:0]         dbg_state;

  assign adc = {adc1, adc0};

  adc_multitrigger_if wb ();

  adc_multitrigger #(
    .CHANNELS      (CHANNELS),
    .ADC_WIDTH     (ADC_WIDTH),
    .HOLDOFF_WIDTH (HOLDOFF_WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sq_active   (sq_active),
    .sq_trigger  (sq_trigger),
    .adc         (adc),
    .wb          (wb.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q [$];
  logic [15:0] adr_q [$];
  int          trig_q [$];
  logic [7:0]  mon_e;
  logic [15:0] mon_a;

  always @(negedge clk) begin
    if (wb.wb_stb_i && wb.wb_cyc_i && !wb.wb_we_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected adr=%h got=%h", wb.wb_adr_i, wb.wb_dat_o);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = adr_q.pop_front();
        if (wb.wb_dat_o !== mon_e) begin
          n_fail++;
          $display("FAIL rd adr=%h got=%h exp=%h", mon_a, wb.wb_dat_o, mon_e);
        end
      end
    end
    if (trig_q.size() > 0 && trig_q[0] < edge_n) begin
      n_checks++;
      n_fail++;
      $display("FAIL trig_missed exp_edge=%0d now=%0d sq_trigger=0 exp=1", trig_q[0], edge_n);
      void'(trig_q.pop_front());
    end
    if (sq_trigger) begin
      n_checks++;
      if (trig_q.size() > 0 && trig_q[0] == edge_n) begin
        void'(trig_q.pop_front());
      end else begin
        n_fail++;
        $display("FAIL trig_unexpected edge=%0d sq_trigger=1 exp=0", edge_n);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [15:0] a, input logic [7:0] d);
    wb.wb_stb_i = 1'b1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_we_i  = 1'b1;
    wb.wb_adr_i = a;
    wb.wb_dat_i = d;
    tick(1);
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_we_i  = 1'b0;
  endtask

  task automatic wb_read(input logic [15:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    adr_q.push_back(a);
    wb.wb_stb_i = 1'b1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = a;
    tick(1);
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
  endtask

  task automatic expect_trig(input int at_edge);
    trig_q.push_back(at_edge);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL timeout edge=%0d", edge_n);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  int w;

  initial begin
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = '0;
    wb.wb_dat_i = '0;
    tick(2);

    // Reset held with writes and toggling samples: nothing may stick.
    sq_active = 1'b1;
    adc0 = 12'h040;
    wb_write(16'h0001, 8'h80);
    adc0 = 12'h900;
    wb_write(16'h0000, 8'h03);
    adc0 = 12'h040;
    wb_write(16'h0081, 8'h05);
    adc1 = 12'h100;
    wb_read(16'h0000, HB);
    wb_read(16'h0001, 8'h00);
    wb_read(16'h0081, 8'h00);
    wb_read(16'h0080, 8'h00);
    n_checks++;
    if (sq_trigger !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_trigger got=%b exp=0", sq_trigger);
    end
    rst_n = 1'b1;
    tick(3);
    wb_read(16'h0000, HB);
    wb_read(16'h0001, 8'h00);
    wb_read(16'h0081, 8'h00);

    // Level mode ch0: pulse every cycle with holdoff 0.
    adc0 = 12'h040;
    adc1 = 12'h000;
    wb_write(16'h0001, 8'h80);
    wb_write(16'h0000, 8'h03);
    w = edge_n;
    for (int i = 2; i <= 9; i++) expect_trig(w + i);
    tick(9);
    sq_active = 1'b0;
    tick(2);
    wb_read(16'h0080, 8'h00);
    wb_read(16'h0000, 8'h03 | HB);

    // Holdoff 3: one pulse every 4 cycles.
    wb_write(16'h0081, 8'h03);
    sq_active = 1'b1;
    w = edge_n;
    expect_trig(w + 1);
    expect_trig(w + 5);
    expect_trig(w + 9);
    expect_trig(w + 13);
    tick(13);
    sq_active = 1'b0;
    wb_read(16'h0081, 8'h03);
    wb_read(16'h0082, 8'h00);
    wb_write(16'h0081, 8'h00);
    wb_write(16'h0000, 8'h00);
    tick(4);

    // Edge mode ch1, threshold 0x800, greater, abs.
    adc1 = 12'hF00;
    wb_write(16'h0009, 8'h00);
    wb_write(16'h000A, 8'h08);
    sq_active = 1'b1;
    wb_write(16'h0008, 8'h07);
    tick(4);
    adc1 = 12'hC00;
    tick(2);
    adc1 = 12'h900;
    tick(2);
    adc1 = 12'h100;
    expect_trig(edge_n + 2);
    tick(12);
    wb_read(16'h0080, 8'h01);
    adc1 = 12'h800;
    tick(3);
    adc1 = 12'h7FF;
    expect_trig(edge_n + 2);
    tick(4);

    // Simultaneous hits on ch0 and ch1: single pulse, lowest index reported.
    adc0 = 12'hF00;
    adc1 = 12'hF00;
    wb_write(16'h0001, 8'h00);
    wb_write(16'h0002, 8'h08);
    wb_write(16'h0000, 8'h07);
    tick(4);
    adc0 = 12'h100;
    adc1 = 12'h100;
    expect_trig(edge_n + 2);
    tick(4);
    wb_read(16'h0080, 8'h00);

    // Crossing while the sequencer is inactive never fires.
    adc0 = 12'hF00;
    adc1 = 12'hF00;
    tick(3);
    sq_active = 1'b0;
    tick(1);
    adc0 = 12'h100;
    adc1 = 12'h100;
    tick(5);
    sq_active = 1'b1;
    tick(6);

    // Register lock while enabled.
    wb_write(16'h0001, 8'h10);
    wb_read(16'h0001, 8'h00);
    wb_read(16'h0002, 8'h08);
    wb_write(16'h0008, 8'h01);
    wb_read(16'h0008, 8'h07 | HB);
    wb_write(16'h0000, 8'h02);
    wb_read(16'h0000, 8'h06 | HB);
    wb_write(16'h0000, 8'h02);
    wb_read(16'h0000, 8'h02 | HB);
    wb_write(16'h0001, 8'h10);
    wb_read(16'h0001, 8'h10);
    wb_write(16'h0002, 8'hFF);
    wb_read(16'h0002, 8'h0F);

    // Absent offsets / channels and global bytes.
    wb_read(16'h0005, 8'h00);
    wb_write(16'h0010, 8'h03);
    wb_read(16'h0010, 8'h00);
    wb_read(16'h0083, 8'h00);
    wb_write(16'h0082, 8'hAB);
    wb_read(16'h0082, 8'hAB);
    wb_write(16'h0082, 8'h00);
    wb_write(16'h0003, 8'h55);
`ifdef ADC_MULTITRIGGER_HYST_EN
    wb_read(16'h0003, 8'h55);
`else
    wb_read(16'h0003, 8'h00);
`endif

`ifdef ADC_MULTITRIGGER_HYST_EN
    // Hysteresis: thresh 0x80, hyst 0x10, greater, abs on ch0.
    wb_write(16'h0008, 8'h00);
    adc0 = 12'h070;
    wb_write(16'h0001, 8'h80);
    wb_write(16'h0002, 8'h00);
    wb_write(16'h0003, 8'h10);
    wb_write(16'h0004, 8'h00);
    wb_write(16'h0000, 8'h07);
    tick(3);
    adc0 = 12'h088;
    tick(3);
    adc0 = 12'h070;
    tick(4);
    adc0 = 12'h091;
    tick(3);
    adc0 = 12'h070;
    expect_trig(edge_n + 2);
    tick(4);
`endif

    tick(10);
    while (trig_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL trig_pending exp_edge=%0d", trig_q.pop_front());
    end
    while (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL rd_pending exp=%h", exp_q.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
